// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller_pkg
//  Description : Shared MIPS multicycle definitions: FSM state codes, opcode
//                constants, ALU operation classes and the control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

    // FSM state codes; 13..15 are unused and treated as illegal
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12
    } state_t;

    // Opcode field values
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // ALU operation classes, shared with the ALU decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_or    = 2'b11;

    // ALU B-source selects
    localparam logic [1:0] c_alub_reg  = 2'b00;
    localparam logic [1:0] c_alub_four = 2'b01;
    localparam logic [1:0] c_alub_imm  = 2'b10;
    localparam logic [1:0] c_alub_bofs = 2'b11;

    // PC source selects
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // Control word produced by the output decoder
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_controller_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mc_outdec
//  Description : Moore output decoder: maps the FSM state to the datapath
//                control word. Illegal codes yield the all-zero word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_outdec
    import mc_controller_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    // Every field defaults to zero; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb = c_alub_four;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = c_alub_bofs;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = c_alub_imm;
                ctrl.aluop   = c_aluop_add;
            end
            S_ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = c_alub_imm;
                ctrl.aluop   = c_aluop_or;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = c_aluop_funct;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_IWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = c_aluop_sub;
                ctrl.pcsrc   = c_pcsrc_aluout;
                ctrl.branch  = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc   = c_pcsrc_jump;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Multicycle MIPS main controller. State register with
//                next-state logic, Moore output decoder, and branch-qualified
//                PC enable. Write strobes are gated off while reset is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    // Held as a plain 4-bit vector so the unused codes 13..15 stay representable
    logic [3:0] r_state;
    ctrl_t      w_ctrl;

    // State register and next-state logic; illegal codes recover to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        c_op_lw, c_op_sw: r_state <= S_MEMADR;
                        c_op_rtype:       r_state <= S_RTYPEEX;
                        c_op_beq:         r_state <= S_BEQEX;
                        c_op_addi:        r_state <= S_ADDIEX;
                        c_op_ori:         r_state <= S_ORIEX;
                        c_op_j:           r_state <= S_JEX;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == c_op_lw) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   r_state <= S_MEMWB;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_ADDIEX:  r_state <= S_IWB;
                S_ORIEX:   r_state <= S_IWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    mc_outdec u_outdec (
        .state (r_state),
        .ctrl  (w_ctrl)
    );

    // Architectural write strobes are suppressed for as long as reset is held
    assign pcen     = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & zero));
    assign memwrite = ~reset & w_ctrl.memwrite;
    assign irwrite  = ~reset & w_ctrl.irwrite;
    assign regwrite = ~reset & w_ctrl.regwrite;

    assign alusrca  = w_ctrl.alusrca;
    assign iord     = w_ctrl.iord;
    assign memtoreg = w_ctrl.memtoreg;
    assign regdst   = w_ctrl.regdst;
    assign alusrcb  = w_ctrl.alusrcb;
    assign pcsrc    = w_ctrl.pcsrc;
    assign aluop    = w_ctrl.aluop;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: op  in  6  opcode field of the instruction register.
REQ-004 SHALL have port: zero  in  1  ALU zero flag from the current cycle.
REQ-005 SHALL have ports: pcen, memwrite, irwrite, regwrite  out  1 each  PC enable, memory write, instruction-register write, register-file write.
REQ-006 SHALL have ports: alusrca, iord, memtoreg, regdst  out  1 each  datapath mux selects.
REQ-007 SHALL have ports: alusrcb, pcsrc, aluop  out  2 each  ALU B-source select, PC source select, ALU-decoder operation class.
REQ-008 SHALL have port: state  out  4  current FSM state, for debug and bench visibility.

Function
REQ-009 SHALL be a Moore FSM: every output except pcen is a pure function of state; pcen = pcwrite | (branch & zero), with pcwrite and branch internal.
REQ-010 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IWB=10, JEX=11, ORIEX=12; codes 13-15 are illegal.
REQ-011 SHALL transition FETCH->DECODE unconditionally.
REQ-012 SHALL decode from DECODE: lw 100011 or sw 101011 ->MEMADR; R-type 000000 ->RTYPEEX; beq 000100 ->BEQEX; addi 001000 ->ADDIEX; ori 001101 ->ORIEX; j 000010 ->JEX; any other op ->FETCH.
REQ-013 SHALL transition MEMADR->MEMRD when op=lw and MEMADR->MEMWR otherwise; MEMRD->MEMWB.
REQ-014 SHALL transition RTYPEEX->RTYPEWB and ADDIEX->IWB and ORIEX->IWB.
REQ-015 SHALL transition MEMWB, MEMWR, RTYPEWB, BEQEX, IWB and JEX to FETCH.
REQ-016 SHALL transition any illegal state code to FETCH on the next edge.
REQ-017 SHALL give every output the default 0 in each state, except as listed in REQ-018 to REQ-028.
REQ-018 FETCH: alusrcb=01, irwrite=1, pcwrite=1.
REQ-019 DECODE: alusrcb=11.
REQ-020 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-021 ORIEX: alusrca=1, alusrcb=10, aluop=11.
REQ-022 MEMRD: iord=1.
REQ-023 MEMWB: regwrite=1, memtoreg=1.
REQ-024 MEMWR: iord=1, memwrite=1.
REQ-025 RTYPEEX: alusrca=1, aluop=10.
REQ-026 RTYPEWB: regwrite=1, regdst=1.
REQ-027 IWB: regwrite=1.
REQ-028 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. JEX: pcsrc=10, pcwrite=1.
REQ-029 SHALL take these cycles per instruction: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3, undefined opcode 2.
REQ-030 SHALL drive all outputs fully defined (no x) in every state, including illegal codes.

Reset
REQ-031 SHALL load state=FETCH on any rising clk with reset=1, regardless of the current state.
REQ-032 SHALL force pcen, memwrite, irwrite and regwrite to 0 combinationally while reset=1, so no architectural write occurs during reset.
REQ-033 SHALL, on the first edge after reset deasserts, perform a normal FETCH (pcen=1, irwrite=1) and then go to DECODE.

Structure
REQ-034 SHALL take state codes, opcode constants and aluop codes (00 add, 01 sub, 10 funct, 11 or) from the shared MIPS package, which the ALU decoder also uses.
REQ-035 SHALL be split into a state register with next-state logic, and an output decoder as one sub-module, mc_outdec (state in, control word out).

Verification
REQ-036 Reset held 3 cycles mid-RTYPEWB -> state=0 and regwrite=0 throughout; after release, pcen=1 and irwrite=1 in the first cycle.
REQ-037 op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-038 op=101011 -> sequence 0,1,2,5,0; memwrite=1 and iord=1 only in state 5.
REQ-039 op=000100, zero=1 then zero=0 -> pcen=1 in BEQEX for the first run, pcen=0 for the second; pcsrc=01 and aluop=01 in both.
REQ-040 op=001101 -> sequence 0,1,12,10,0 with aluop=11 in state 12; op=000010 -> sequence 0,1,11,0 with pcsrc=10 and pcen=1.
REQ-041 op=111111 -> DECODE->FETCH with no write strobe; forced state=13 -> state=0 next cycle.
